// File: rtl/video_timing_pkg.sv
// Shared types and limits for the video timing generator.
package video_timing_pkg;

  localparam int unsigned MAX_PIPE_LAT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth delay line with a synchronous reset value; depth 0 is a plain wire.
module pipe_delay #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n;
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift register; reset loads every stage so no stale pulses emerge afterwards.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= RST_VAL;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: early-timed pixel request plus delay-aligned syncs/enables.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned HACTIVE   = 640,
  parameter int unsigned HFPORCH   = 16,
  parameter int unsigned HSYNC     = 96,
  parameter int unsigned HBPORCH   = 48,
  parameter logic        HSYNC_POL = 1'b0,
  parameter int unsigned VACTIVE   = 480,
  parameter int unsigned VFPORCH   = 10,
  parameter int unsigned VSYNC     = 2,
  parameter int unsigned VBPORCH   = 33,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic             pix_clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             pix_req,
  output logic [CNT_W-1:0] req_row,
  output logic [CNT_W-1:0] req_col,
  output logic             hsync,
  output logic             vsync,
  output logic             disp_en,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int unsigned HTOTAL  = HACTIVE + HFPORCH + HSYNC + HBPORCH;
  localparam int unsigned VTOTAL  = VACTIVE + VFPORCH + VSYNC + VBPORCH;
  localparam int unsigned HS_BEG  = HACTIVE + HFPORCH;
  localparam int unsigned HS_END  = HS_BEG + HSYNC;
  localparam int unsigned VS_BEG  = VACTIVE + VFPORCH;
  localparam int unsigned VS_END  = VS_BEG + VSYNC;
  localparam int unsigned EARLY_W = 5;
  localparam logic [EARLY_W-1:0] EARLY_IDLE = {~HSYNC_POL, ~VSYNC_POL, 3'b000};

  // Reject configurations the counters or the delay line cannot represent.
  if (HTOTAL > (1 << CNT_W)) begin : g_bad_htotal
    $error("video_timing_gen: horizontal total exceeds counter range");
  end
  if (VTOTAL > (1 << CNT_W)) begin : g_bad_vtotal
    $error("video_timing_gen: vertical total exceeds counter range");
  end
  if (PIPE_LAT > MAX_PIPE_LAT) begin : g_bad_lat
    $error("video_timing_gen: PIPE_LAT out of range");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_col;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   w_col_nxt;
  logic [CNT_W-1:0]   w_row_nxt;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_run;
  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_de;
  logic [EARLY_W-1:0] w_early;
  logic [EARLY_W-1:0] w_late;

  assign w_last_col = (r_col == CNT_W'(HTOTAL - 1));
  assign w_last_row = (r_row == CNT_W'(VTOTAL - 1));

  // State and raster counters.
  always_ff @(posedge pix_clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next state: start on enable, stop only at the last pixel of a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    case (r_state)
      IDLE: begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        if (enable) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last_col) begin
          w_col_nxt = '0;
          if (w_last_row) begin
            w_row_nxt = '0;
            if (!enable) w_state_nxt = IDLE;
          end else begin
            w_row_nxt = r_row + CNT_W'(1);
          end
        end else begin
          w_col_nxt = r_col + CNT_W'(1);
        end
      end
    endcase
  end

  // Early-timed decode of the current raster position.
  assign w_run    = (r_state == RUN);
  assign w_de     = w_run && (r_row < CNT_W'(VACTIVE)) && (r_col < CNT_W'(HACTIVE));
  assign w_hs_act = w_run && (r_col >= CNT_W'(HS_BEG)) && (r_col < CNT_W'(HS_END));
  assign w_vs_act = w_run && (r_row >= CNT_W'(VS_BEG)) && (r_row < CNT_W'(VS_END));
  assign w_early  = {w_hs_act ? HSYNC_POL : ~HSYNC_POL,
                     w_vs_act ? VSYNC_POL : ~VSYNC_POL,
                     w_de,
                     w_run && (r_col == '0),
                     w_run && (r_col == '0) && (r_row == '0)};

  pipe_delay #(
    .WIDTH   (EARLY_W),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (EARLY_IDLE)
  ) u_pipe (
    .i_clk   (pix_clk),
    .i_rst_n (reset_n),
    .i_d     (w_early),
    .o_q     (w_late)
  );

  assign pix_req     = w_de;
  assign req_row     = r_row;
  assign req_col     = r_col;
  assign running     = w_run;
  assign hsync       = w_late[4];
  assign vsync       = w_late[3];
  assign disp_en     = w_late[2];
  assign line_start  = w_late[1];
  assign frame_start = w_late[0];

endmodule
